if_id_fetch_stage: RTL and testbench

- Instruction-fetch end of the load-use stall interface. Owns the PC register and the IF/ID pipeline register.
- Consumes the hold requests from the hazard detection unit: PC hold and IF/ID hold, both 1 = stall. Also consumes the ID-stage branch/jump flush.
- Drives the instruction-memory address and presents the fetched instruction and PC+4 to the ID stage.
- Tracks stall cycles for debug and flags stalls that last longer than expected.

---
 rtl/if_id_fetch_stage.sv | 124 ++++++++++++
 tb/tb_if_id_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Fetch end of the load-use stall interface: PC register, IF/ID pipeline register,
// and stall-cycle accounting (a saturating total plus a sticky over-long-stall flag).
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_stall_i,
  input  logic             ifid_stall_i,
  input  logic             flush_i,
  input  logic [31:0]      target_i,
  input  logic [31:0]      inst_mem_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_inst_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             stall_err_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int unsigned RUN_W = 5;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      inst_q, inst_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;

  logic             active;
  logic             stall_cycle;
  logic [31:0]      pc_plus4;

  // The edge that leaves IDLE already performs a fetch, so behaviour keys off start_i.
  assign active      = start_i;
  assign stall_cycle = active & (pc_stall_i | ifid_stall_i);
  assign pc_plus4    = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)  state_d = RUN;
      RUN:     if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (!active) begin
      inst_d  = 32'h0;
      valid_d = 1'b0;
    end else if (ifid_stall_i) begin
      // Hold everything; a flush now would use branch operands that are not ready.
    end else if (pc_stall_i) begin
      inst_d  = 32'h0;
      valid_d = 1'b0;
    end else if (flush_i) begin
      pc_d    = target_i;
      pc4_d   = 32'h0;
      inst_d  = 32'h0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      pc4_d   = pc_plus4;
      inst_d  = inst_mem_i;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (stall_cycle) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      // Saturating at the limit is enough: the error flag is sticky once reached.
      if (run_q != RUN_LIMIT) run_d = run_q + 1'b1;
    end else if (active) begin
      run_d = '0;
    end
    err_d = err_q | (run_d == RUN_LIMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= 32'h0;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign pc_o         = pc_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_inst_o  = inst_q;
  assign ifid_valid_o = valid_q;
  assign stall_cnt_o  = cnt_q;
  assign stall_err_o  = err_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed scenarios then random traffic,
// expected IF/ID and PC state pushed per edge and checked by an independent monitor.
module tb_if_id_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MAX_STALL = 2;
  localparam int          CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic             pc_stall_i = 1'b0;
  logic             ifid_stall_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [31:0]      target_i = 32'h0;
  logic [31:0]      inst_mem_i;
  logic [31:0]      pc_o, ifid_pc4_o, ifid_inst_o;
  logic             ifid_valid_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             stall_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  assign inst_mem_i = mem[pc_o[9:2]];

  if_id_fetch_stage #(.RESET_PC(RESET_PC), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_stall_i(pc_stall_i),
    .ifid_stall_i(ifid_stall_i), .flush_i(flush_i), .target_i(target_i),
    .inst_mem_i(inst_mem_i), .pc_o(pc_o), .ifid_pc4_o(ifid_pc4_o),
    .ifid_inst_o(ifid_inst_o), .ifid_valid_o(ifid_valid_o),
    .stall_cnt_o(stall_cnt_o), .stall_err_o(stall_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, pc4, inst;
    logic        valid;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference state, updated with plain arithmetic from the behavioural rules.
  logic [31:0] m_pc, m_pc4, m_inst, m_cnt;
  logic        m_valid, m_err;
  int          m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pc4 = 0; m_inst = 0; m_valid = 0;
    m_cnt = 0; m_err = 0; m_run = 0;
  endtask

  // One clock: drive at the falling edge and push what the following rising edge must produce.
  task automatic cycle(input logic st, input logic ps, input logic is, input logic fl,
                       input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    start_i = st; pc_stall_i = ps; ifid_stall_i = is; flush_i = fl; target_i = tgt;
    if (!st) begin
      m_inst = 0; m_valid = 0;
    end else begin
      if (is) begin
      end else if (ps) begin
        m_inst = 0; m_valid = 0;
      end else if (fl) begin
        m_pc = tgt; m_pc4 = 0; m_inst = 0; m_valid = 0;
      end else begin
        m_inst = mem[m_pc[9:2]]; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end
      if (ps || is) begin
        if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        m_run = m_run + 1;
        if (m_run > MAX_STALL) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    e.pc = m_pc; e.pc4 = m_pc4; e.inst = m_inst; e.valid = m_valid;
    e.cnt = m_cnt; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Reset raised mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    start_i = 0; pc_stall_i = 0; ifid_stall_i = 0; flush_i = 0;
    #2 rst_i = 1;
    #1;
    check("async_rst_pc", pc_o, RESET_PC);
    check("async_rst_valid", {31'b0, ifid_valid_o}, 32'h0);
    check("async_rst_inst", ifid_inst_o, 32'h0);
    check("async_rst_pc4", ifid_pc4_o, 32'h0);
    check("async_rst_cnt", {16'b0, stall_cnt_o}, 32'h0);
    check("async_rst_err", {31'b0, stall_err_o}, 32'h0);
    @(negedge clk);
    rst_i = 0;
    model_reset();
  endtask

  // Directed spot checks just after the rising edge that the last cycle() set up.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_pc4", ifid_pc4_o, e.pc4);
        check("sb_inst", ifid_inst_o, e.inst);
        check("sb_valid", {31'b0, ifid_valid_o}, {31'b0, e.valid});
        check("sb_cnt", {16'b0, stall_cnt_o}, e.cnt);
        check("sb_err", {31'b0, stall_err_o}, {31'b0, e.err});
      end
    end
  end

  initial begin : stimulus
    int waited;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2002_0005;
    model_reset();
    do_reset();

    // First fetches from RESET_PC.
    cycle(1, 0, 0, 0, 0); after_edge();
    check("first_pc", pc_o, 32'd4);
    check("first_inst", ifid_inst_o, 32'h2002_0005);
    check("first_pc4", ifid_pc4_o, 32'd4);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0); after_edge();
    check("three_edges_pc", pc_o, 32'd12);
    // Single stall pair: PC and IF/ID hold.
    do_reset();
    cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0); after_edge();
    check("stall_pc", pc_o, 32'd8);
    check("stall_cnt", {16'b0, stall_cnt_o}, 32'd1);
    cycle(1, 0, 0, 0, 0); after_edge();
    check("post_stall_pc", pc_o, 32'd12);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 32'h40); after_edge();
    check("flush_pc", pc_o, 32'h40);
    check("flush_valid", {31'b0, ifid_valid_o}, 32'h0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'h80); after_edge();
    check("stall_flush_pc", pc_o, 32'h44);
    cycle(1, 0, 0, 1, 32'h80); after_edge();
    check("flush_after_stall_pc", pc_o, 32'h80);

    // Over-long stall sets the sticky error.
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0); cycle(1, 1, 1, 0, 0); after_edge();
    check("err_after_2", {31'b0, stall_err_o}, 32'h0);
    cycle(1, 1, 1, 0, 0); after_edge();
    check("err_after_3", {31'b0, stall_err_o}, 32'h1);
    check("cnt_after_3", {16'b0, stall_cnt_o}, 32'd3);
    cycle(1, 0, 0, 0, 0); after_edge();
    check("err_sticky", {31'b0, stall_err_o}, 32'h1);
    do_reset();

    // PC wrap, then dropping start_i.
    cycle(1, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0, 0); after_edge();
    check("wrap_pc", pc_o, 32'h0);
    cycle(0, 0, 0, 0, 0); after_edge();
    check("idle_pc_hold", pc_o, 32'h0);
    check("idle_valid", {31'b0, ifid_valid_o}, 32'h0);

    // Random traffic; occasional resets and idle stretches.
    for (int i = 0; i < 3000; i++) begin
      logic st, ps, is, fl;
      if ($urandom_range(0, 199) == 0) do_reset();
      st = ($urandom_range(0, 9) != 0);
      ps = ($urandom_range(0, 4) == 0);
      is = ps ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 19) == 0);
      fl = ($urandom_range(0, 7) == 0);
      cycle(st, ps, is, fl, {$urandom} & 32'hFFFF_FFFC);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
